// File: rtl/uart_hex_rx.sv
// rtl/uart_hex_rx.sv - 8N1 UART receiver with ASCII-hex line decoder (16-bit word per CR/LF line)
// Optional terminal echo outputs are enabled by defining UART_HEX_RX_ECHO_EN.
module uart_hex_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int MAX_DIGITS   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        uart_rx,
   output logic [15:0] value,
   output logic        value_valid,
   output logic        line_err,
   output logic        echo_req,
   output logic [7:0]  echo_data
);
   localparam int CW       = $clog2(CLKS_PER_BIT);
   localparam int HALF     = CLKS_PER_BIT / 2;
   localparam int CNT_W    = $clog2(MAX_DIGITS + 1);
   localparam int ACC_BITS = (MAX_DIGITS >= 4) ? 16 : 4 * MAX_DIGITS;
   localparam logic [15:0] ACC_MASK = 16'((33'h1 << ACC_BITS) - 33'h1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t            state_q, state_d;
   logic              rx_meta_q, rxs_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        sh_q, sh_d;
   logic              stop_wait_q, stop_wait_d;
   logic              byte_stb_q, byte_stb_d;
   logic [15:0]       acc_q, acc_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              discard_q, discard_d;
   logic [15:0]       value_q, value_d;
   logic              value_valid_q, value_valid_d;
   logic              line_err_q, line_err_d;
   logic              stop_ok;

   function automatic logic is_hex(input logic [7:0] c);
      return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66);
   endfunction

   // Letters 'A'-'F' and 'a'-'f' both carry 1..6 in their low nibble.
   function automatic logic [3:0] hex_nib(input logic [7:0] c);
      return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
   endfunction

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bit_d         = bit_q;
      sh_d          = sh_q;
      stop_wait_d   = stop_wait_q;
      byte_stb_d    = 1'b0;
      acc_d         = acc_q;
      count_d       = count_q;
      discard_d     = discard_q;
      value_d       = value_q;
      value_valid_d = 1'b0;
      line_err_d    = 1'b0;
      stop_ok       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!rxs_q) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == CW'(HALF - 1)) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rxs_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d = '0;
               sh_d  = {rxs_q, sh_q[7:1]};
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (stop_wait_q) begin
               if (rxs_q) begin
                  stop_wait_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d = '0;
               if (rxs_q) begin
                  stop_ok    = 1'b1;
                  byte_stb_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  // Framing error: drop the byte and the rest of the line.
                  stop_wait_d = 1'b1;
                  line_err_d  = 1'b1;
                  discard_d   = 1'b1;
                  acc_d       = '0;
                  count_d     = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase

      if (byte_stb_q) begin
         if (sh_q == 8'h0D || sh_q == 8'h0A) begin
            if (!discard_q && count_q != '0) begin
               value_d       = acc_q;
               value_valid_d = 1'b1;
            end
            discard_d = 1'b0;
            acc_d     = '0;
            count_d   = '0;
         end else if (!discard_q) begin
            if (is_hex(sh_q)) begin
               acc_d = {acc_q[11:0], hex_nib(sh_q)} & ACC_MASK;
               if (count_q < CNT_W'(MAX_DIGITS)) count_d = count_q + 1'b1;
            end else if (sh_q == 8'h78 || sh_q == 8'h58) begin
               acc_d   = '0;
               count_d = '0;
            end else if (sh_q != 8'h20) begin
               line_err_d = 1'b1;
               discard_d  = 1'b1;
               acc_d      = '0;
               count_d    = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q     <= 1'b1;
         rxs_q         <= 1'b1;
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         bit_q         <= '0;
         sh_q          <= '0;
         stop_wait_q   <= 1'b0;
         byte_stb_q    <= 1'b0;
         acc_q         <= '0;
         count_q       <= '0;
         discard_q     <= 1'b0;
         value_q       <= '0;
         value_valid_q <= 1'b0;
         line_err_q    <= 1'b0;
      end else begin
         rx_meta_q     <= uart_rx;
         rxs_q         <= rx_meta_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_q         <= bit_d;
         sh_q          <= sh_d;
         stop_wait_q   <= stop_wait_d;
         byte_stb_q    <= byte_stb_d;
         acc_q         <= acc_d;
         count_q       <= count_d;
         discard_q     <= discard_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         line_err_q    <= line_err_d;
      end
   end

   assign value       = value_q;
   assign value_valid = value_valid_q;
   assign line_err    = line_err_q;

`ifdef UART_HEX_RX_ECHO_EN
   logic       echo_req_q;
   logic [7:0] echo_data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         echo_req_q  <= 1'b0;
         echo_data_q <= '0;
      end else begin
         echo_req_q <= stop_ok;
         if (stop_ok) echo_data_q <= sh_q;
      end
   end

   assign echo_req  = echo_req_q;
   assign echo_data = echo_data_q;
`else
   assign echo_req  = 1'b0;
   assign echo_data = 8'h00;
`endif

endmodule

// File: tb/tb_uart_hex_rx.sv
// tb/tb_uart_hex_rx.sv - scoreboard testbench for uart_hex_rx at CLKS_PER_BIT=16
module tb_uart_hex_rx;
   localparam int CLKS = 16;
   // Start edge driven just after edge k: 2 sync flops, 1 idle-detect cycle, CLKS/2 start,
   // 9*CLKS to the stop sample, then 2 cycles to the registered strobe.
   localparam int LAT  = 3 + CLKS / 2 + 9 * CLKS + 1;

   typedef struct {
      logic        is_err;
      logic [15:0] val;
      int          exp_cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        uart_rx = 1'b1;
   logic [15:0] value;
   logic        value_valid;
   logic        line_err;
   logic        echo_req;
   logic [7:0]  echo_data;

   ev_t sb_q[$];
   int  n_chk = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  good_frames = 0;
   int  echo_cnt = 0;

   uart_hex_rx #(.CLKS_PER_BIT(CLKS), .MAX_DIGITS(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .uart_rx     (uart_rx),
      .value       (value),
      .value_valid (value_valid),
      .line_err    (line_err),
      .echo_req    (echo_req),
      .echo_data   (echo_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic is_err, input logic [15:0] val, input int exp_cyc);
      ev_t e;
      e.is_err  = is_err;
      e.val     = val;
      e.exp_cyc = exp_cyc;
      sb_q.push_back(e);
   endtask

   // Called positioned just after a rising edge; returns likewise, line idle-high.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (CLKS) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CLKS) @(posedge clk);
         #1;
      end
      uart_rx = stop_bit;
      repeat (CLKS) @(posedge clk);
      #1;
      if (stop_bit) begin
         good_frames++;
      end else begin
         uart_rx = 1'b1;
         repeat (CLKS) @(posedge clk);
         #1;
      end
      uart_rx = 1'b1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      ev_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (echo_req) echo_cnt++;
            if (value_valid && line_err) begin
               check("valid_and_err_together", 32'(value_valid & line_err), 32'h0);
            end else if (value_valid || line_err) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_strobe", {30'h0, value_valid, line_err}, 32'h0);
               end else begin
                  e = sb_q.pop_front();
                  check("strobe_kind_is_err", 32'(line_err), 32'(e.is_err));
                  if (!e.is_err) check("value", 32'(value), 32'(e.val));
                  if (e.exp_cyc >= 0) check("strobe_latency_cycle", cyc, e.exp_cyc);
               end
            end
         end
      end
   end

   initial begin : stim
      int exp_echo;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_value", 32'(value), 32'h0);
      check("reset_value_valid", 32'(value_valid), 32'h0);
      check("reset_line_err", 32'(line_err), 32'h0);
      check("reset_echo_req", 32'(echo_req), 32'h0);
      check("reset_echo_data", 32'(echo_data), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(5);

      send_str("1A2b");
      push(1'b0, 16'h1A2B, cyc + LAT);
      send_byte(8'h0D, 1'b1);

      push(1'b0, 16'h00FF, -1);
      send_str("0x00ff\r\n");

      push(1'b1, 16'h0, -1);
      push(1'b0, 16'hBEEF, -1);
      send_str("12G4\r");
      send_str("beef\n");

      push(1'b0, 16'h3456, -1);
      send_str("123456\r");
      idle(10);

      send_str("12");
      idle(3);
      reset = 1'b1;
      idle(3);
      @(negedge clk);
      check("midline_reset_value", 32'(value), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(5);
      send_str("\r");

      uart_rx = 1'b0;
      idle(4);
      uart_rx = 1'b1;
      idle(40);
      push(1'b0, 16'h0007, -1);
      send_str("7\r");

      push(1'b1, 16'h0, -1);
      send_byte(8'h35, 1'b0);
      send_str("9\r");
      push(1'b0, 16'h0009, -1);
      send_str("9\r");

      idle(200);
      check("scoreboard_drained", sb_q.size(), 32'h0);
      check("final_value", 32'(value), 32'h0009);
`ifdef UART_HEX_RX_ECHO_EN
      exp_echo = good_frames;
`else
      exp_echo = 0;
`endif
      check("echo_count", echo_cnt, exp_echo);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
